intr_arbiter: RTL and testbench
===============================

// Module: intr_arbiter
// PURPOSE
//  Unibus interrupt arbiter for one BR level. It sits downstream of device blocks
//  such as the RL11, collecting their intreq/irvec pairs.
//  It runs the BR/BG/SACK/BBSY/INTR handshake and drives the winning vector onto D.
//  It returns intgnt/igvec so the winning device clears its request.
//  One instance is built per BR level; grants not claimed here pass downstream on bg_out.
// PARAMETERS
//  NDEV     4     number of device request inputs; index 0 is highest priority
//  TIMEOUT  1023  cycles to wait for SSYN in VECT before aborting (INTARB_TIMEOUT_EN only)
// PORTS
//  CLOCK           in   1       system clock
//  RESET           in   1       synchronous, active-high
//  init_in_h       in   1       bus INIT; same effect as RESET on all state and outputs
//  intreqs         in   NDEV    device interrupt requests, level
//  irvecs          in   8*NDEV  device vectors; [8i+7:8i] belongs to device i
//  intgnt          out  1       one-cycle pulse: vector accepted by the CPU
//  igvec           out  8       vector that was accepted; valid while intgnt=1
//  bus_br_out_h    out  1       BRn request to the CPU
//  bus_bg_in_h     in   1       BGn grant arriving from upstream
//  bus_bg_out_h    out  1       BGn grant passed to downstream devices
//  bus_sack_out_h  out  1       SACK
//  bus_bbsy_in_h   in   1       BBSY seen on the bus from other masters
//  bus_bbsy_out_h  out  1       BBSY driven by this block
//  bus_ssyn_in_h   in   1       SSYN from the CPU
//  bus_intr_out_h  out  1       INTR
//  bus_d_out_h     out  16      data lines; {8'b0, vector} while VECT, else 0
// BEHAVIOUR
//  - Reset values: all outputs 0; state IDLE; lastbg=0.
//  - bgrise = bus_bg_in_h & ~lastbg. lastbg is registered every cycle.
//  - win: lowest index i with intreqs[i]=1.
//  - IDLE
//      bus_br_out_h <= |intreqs (registered, 1-cycle latency).
//      On bgrise with |intreqs: latch win and its vector into vec;
//        sack<=1, br<=0; go to GRANT.
//      On bgrise with no request: bg_out<=1; go to PASS.
//  - PASS
//      bg_out follows bus_bg_in_h; when bg_in=0, bg_out<=0 and go to IDLE.
//  - GRANT
//      Wait until bg_in=0 & bbsy_in=0 & ssyn_in=0.
//      Then bbsy_out<=1, d_out<={8'b0,vec}; go to DESKEW.
//  - DESKEW
//      One cycle with data stable. Then intr<=1, sack<=0; go to VECT.
//  - VECT
//      When ssyn_in=1: intgnt<=1 for exactly one cycle, igvec<=vec;
//        intr, bbsy_out, d_out <= 0; go to WSSYN.
//  - WSSYN
//      Wait ssyn_in=0, then go to IDLE.
//      br may reassert 1 cycle after entry to IDLE.
//  - Request state is latched at bgrise. A device dropping intreq after that
//    point still has vec delivered and still gets intgnt.
//    New or higher-priority requests wait for the next BR cycle.
//  - igvec is held between pulses. Devices compare igvec to their own vector
//    only while intgnt=1.
//  - RESET or init_in_h in any state: immediate return to IDLE with all outputs 0.
//    intgnt is not pulsed for an aborted vector.
//  - bgrise while not in IDLE is ignored. Grants are never passed downstream
//    while SACK is held.
// CONFIGURATION
//  INTARB_TIMEOUT_EN defined:
//    - A 10-bit counter is cleared on entry to VECT and increments each cycle there.
//    - When the count reaches TIMEOUT: intr, bbsy_out, d_out <= 0, go to IDLE,
//      no intgnt pulse. The request, if still asserted, re-arbitrates.
//  INTARB_TIMEOUT_EN undefined:
//    - No counter. VECT waits for SSYN indefinitely.
// TESTING
//  1. intreqs=4'b0100, irvecs[23:16]=8'o160, grant, SSYN
//     -> D=16'o000160 with INTR; intgnt pulses once with igvec=8'o160; br then drops.
//  2. intreqs=4'b0110 -> vector of dev1 delivered first; dev2's vector on the next BR/BG cycle.
//  3. intreqs=0, BG pulsed -> bg_out follows BG; no SACK, no BBSY.
//  4. bbsy_in=1 held after grant -> stays in GRANT with SACK=1 until bbsy_in falls;
//     BBSY is then asserted next cycle.
//  5. init_in_h asserted during VECT -> next cycle all outputs 0, state IDLE,
//     no intgnt pulse.
//  6. INTARB_TIMEOUT_EN, TIMEOUT=16, no SSYN -> INTR drops after 16 cycles in VECT;
//     no intgnt pulse; br reasserts while the request stays held.

Source files
------------

// File: rtl/intr_arbiter.sv
// -----------------------------------------------------------------------------
// intr_arbiter
//
// Unibus interrupt arbiter for a single BR level. Collects level-sensitive
// requests and vectors from up to NDEV devices (index 0 = highest priority),
// runs the BR/BG/SACK/BBSY/INTR handshake, puts the winning vector on the data
// lines and reports the accepted vector back to the devices via intgnt/igvec.
// Grants that arrive with no local request are passed downstream on bg_out.
//
// Optional feature macro: INTARB_TIMEOUT_EN
//   defined   -> VECT aborts after TIMEOUT cycles without SSYN (no intgnt).
//   undefined -> VECT waits for SSYN indefinitely.
//
// Ports
//   CLOCK, RESET     clock, synchronous active-high reset
//   init_in_h        bus INIT, same effect as RESET
//   intreqs/irvecs   device requests (level) and their 8-bit vectors
//   intgnt/igvec     one-cycle accept pulse and the accepted vector (held)
//   bus_br_out_h     BR request to the CPU
//   bus_bg_in_h      BG from upstream; bus_bg_out_h BG passed downstream
//   bus_sack_out_h   SACK
//   bus_bbsy_in_h    BBSY from other masters; bus_bbsy_out_h our BBSY
//   bus_ssyn_in_h    SSYN from the CPU
//   bus_intr_out_h   INTR
//   bus_d_out_h      data lines, {8'b0, vector} while presenting the vector
//
// State table
//   state  | meaning
//   IDLE   | tracking requests on BR, waiting for a BG rising edge
//   PASS   | no local request at grant; BG forwarded downstream
//   GRANT  | SACK held, waiting for BG, BBSY and SSYN to be released
//   DESKEW | BBSY and data driven, one cycle for the data to settle
//   VECT   | INTR asserted, waiting for SSYN from the CPU
//   WSSYN  | vector accepted, waiting for SSYN to drop
// -----------------------------------------------------------------------------
module intr_arbiter #(
  parameter int NDEV    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              init_in_h,
  input  logic [NDEV-1:0]   intreqs,
  input  logic [8*NDEV-1:0] irvecs,
  output logic              intgnt,
  output logic [7:0]        igvec,
  output logic              bus_br_out_h,
  input  logic              bus_bg_in_h,
  output logic              bus_bg_out_h,
  output logic              bus_sack_out_h,
  input  logic              bus_bbsy_in_h,
  output logic              bus_bbsy_out_h,
  input  logic              bus_ssyn_in_h,
  output logic              bus_intr_out_h,
  output logic [15:0]       bus_d_out_h
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PASS   = 3'd1;
  localparam logic [2:0] ST_GRANT  = 3'd2;
  localparam logic [2:0] ST_DESKEW = 3'd3;
  localparam logic [2:0] ST_VECT   = 3'd4;
  localparam logic [2:0] ST_WSSYN  = 3'd5;

  // TIMEOUT has to fit the 10-bit VECT counter; an out-of-range setting
  // shows up as this named block in the elaborated hierarchy.
  if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_timeout_out_of_range
  end

  logic [2:0]  r_state;
  logic        r_lastbg;
  logic [7:0]  r_vec;
  logic        r_intgnt;
  logic [7:0]  r_igvec;
  logic        r_br;
  logic        r_bg_out;
  logic        r_sack;
  logic        r_bbsy;
  logic        r_intr;
  logic [15:0] r_d;

  logic        w_bgrise;
  logic        w_any;
  logic [7:0]  w_win_vec;
  logic        w_bus_free;

`ifdef INTARB_TIMEOUT_EN
  localparam logic [9:0] TIMEOUT_TC = 10'(TIMEOUT - 1);
  logic [9:0] r_vect_cnt;
`endif

  assign w_bgrise   = bus_bg_in_h & ~r_lastbg;
  assign w_any      = |intreqs;
  assign w_bus_free = ~bus_bg_in_h & ~bus_bbsy_in_h & ~bus_ssyn_in_h;

  // Walk from the lowest priority up so the lowest requesting index wins.
  always_comb begin
    w_win_vec = 8'h00;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (intreqs[i]) begin
        w_win_vec = irvecs[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET || init_in_h) begin
      r_state  <= ST_IDLE;
      r_lastbg <= 1'b0;
      r_vec    <= 8'h00;
      r_intgnt <= 1'b0;
      r_igvec  <= 8'h00;
      r_br     <= 1'b0;
      r_bg_out <= 1'b0;
      r_sack   <= 1'b0;
      r_bbsy   <= 1'b0;
      r_intr   <= 1'b0;
      r_d      <= 16'h0000;
`ifdef INTARB_TIMEOUT_EN
      r_vect_cnt <= 10'd0;
`endif
    end else begin
      r_lastbg <= bus_bg_in_h;
      r_intgnt <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_br <= w_any;
          if (w_bgrise) begin
            if (w_any) begin
              // Request set is frozen here; later changes wait for the next BR.
              r_vec   <= w_win_vec;
              r_sack  <= 1'b1;
              r_br    <= 1'b0;
              r_state <= ST_GRANT;
            end else begin
              r_bg_out <= 1'b1;
              r_state  <= ST_PASS;
            end
          end
        end

        ST_PASS: begin
          r_bg_out <= bus_bg_in_h;
          if (!bus_bg_in_h) begin
            r_state <= ST_IDLE;
          end
        end

        ST_GRANT: begin
          if (w_bus_free) begin
            r_bbsy  <= 1'b1;
            r_d     <= {8'h00, r_vec};
            r_state <= ST_DESKEW;
          end
        end

        ST_DESKEW: begin
          r_intr  <= 1'b1;
          r_sack  <= 1'b0;
          r_state <= ST_VECT;
`ifdef INTARB_TIMEOUT_EN
          r_vect_cnt <= 10'd0;
`endif
        end

        ST_VECT: begin
          if (bus_ssyn_in_h) begin
            r_intgnt <= 1'b1;
            r_igvec  <= r_vec;
            r_intr   <= 1'b0;
            r_bbsy   <= 1'b0;
            r_d      <= 16'h0000;
            r_state  <= ST_WSSYN;
          end
`ifdef INTARB_TIMEOUT_EN
          else if (r_vect_cnt == TIMEOUT_TC) begin
            // Count would reach TIMEOUT this cycle: give up the bus silently.
            r_intr  <= 1'b0;
            r_bbsy  <= 1'b0;
            r_d     <= 16'h0000;
            r_state <= ST_IDLE;
          end else begin
            r_vect_cnt <= r_vect_cnt + 10'd1;
          end
`endif
        end

        ST_WSSYN: begin
          if (!bus_ssyn_in_h) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_br     <= 1'b0;
          r_bg_out <= 1'b0;
          r_sack   <= 1'b0;
          r_bbsy   <= 1'b0;
          r_intr   <= 1'b0;
          r_d      <= 16'h0000;
        end
      endcase
    end
  end

  assign intgnt         = r_intgnt;
  assign igvec          = r_igvec;
  assign bus_br_out_h   = r_br;
  assign bus_bg_out_h   = r_bg_out;
  assign bus_sack_out_h = r_sack;
  assign bus_bbsy_out_h = r_bbsy;
  assign bus_intr_out_h = r_intr;
  assign bus_d_out_h    = r_d;

endmodule

// File: tb/tb_intr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_intr_arbiter
//
// Directed bench for intr_arbiter. Inputs change 1 ns after the rising edge and
// outputs are checked there too, so every check sees the state the last edge
// produced. Expected values are hand-derived from the handshake sequence.
// -----------------------------------------------------------------------------
module tb_intr_arbiter;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        init_in_h;
  logic [3:0]  intreqs;
  logic [31:0] irvecs;
  logic        intgnt;
  logic [7:0]  igvec;
  logic        bus_br_out_h;
  logic        bus_bg_in_h;
  logic        bus_bg_out_h;
  logic        bus_sack_out_h;
  logic        bus_bbsy_in_h;
  logic        bus_bbsy_out_h;
  logic        bus_ssyn_in_h;
  logic        bus_intr_out_h;
  logic [15:0] bus_d_out_h;

  int n_checks = 0;
  int n_errors = 0;
  int n_gnt    = 0;

  intr_arbiter #(.NDEV(4), .TIMEOUT(16)) dut (
    .CLOCK          (CLOCK),
    .RESET          (RESET),
    .init_in_h      (init_in_h),
    .intreqs        (intreqs),
    .irvecs         (irvecs),
    .intgnt         (intgnt),
    .igvec          (igvec),
    .bus_br_out_h   (bus_br_out_h),
    .bus_bg_in_h    (bus_bg_in_h),
    .bus_bg_out_h   (bus_bg_out_h),
    .bus_sack_out_h (bus_sack_out_h),
    .bus_bbsy_in_h  (bus_bbsy_in_h),
    .bus_bbsy_out_h (bus_bbsy_out_h),
    .bus_ssyn_in_h  (bus_ssyn_in_h),
    .bus_intr_out_h (bus_intr_out_h),
    .bus_d_out_h    (bus_d_out_h)
  );

  always #5 CLOCK = ~CLOCK;

  // Every cycle intgnt is high counts as one pulse-cycle.
  always @(negedge CLOCK) begin
    if (intgnt) n_gnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, expected to finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Full grant cycle starting in IDLE with BR already up.
  task automatic grant_cycle(input string tag, input logic [7:0] exp_vec, input bit drop_req);
    int g0;
    bus_bg_in_h = 1'b1;
    step();
    check({tag, " sack"}, 32'(bus_sack_out_h), 32'd1);
    check({tag, " br off"}, 32'(bus_br_out_h), 32'd0);
    check({tag, " bg_out"}, 32'(bus_bg_out_h), 32'd0);
    if (drop_req) intreqs = 4'b0000;
    bus_bg_in_h = 1'b0;
    step();
    check({tag, " bbsy"}, 32'(bus_bbsy_out_h), 32'd1);
    check({tag, " d"}, 32'(bus_d_out_h), {24'd0, exp_vec});
    check({tag, " intr early"}, 32'(bus_intr_out_h), 32'd0);
    step();
    check({tag, " intr"}, 32'(bus_intr_out_h), 32'd1);
    check({tag, " sack off"}, 32'(bus_sack_out_h), 32'd0);
    check({tag, " d vect"}, 32'(bus_d_out_h), {24'd0, exp_vec});
    g0 = n_gnt;
    bus_ssyn_in_h = 1'b1;
    step();
    check({tag, " intgnt"}, 32'(intgnt), 32'd1);
    check({tag, " igvec"}, 32'(igvec), {24'd0, exp_vec});
    check({tag, " outs cleared"}, {29'd0, bus_intr_out_h, bus_bbsy_out_h, |bus_d_out_h}, 32'd0);
    step();
    check({tag, " intgnt end"}, 32'(intgnt), 32'd0);
    check({tag, " igvec held"}, 32'(igvec), {24'd0, exp_vec});
    check({tag, " one pulse"}, 32'(n_gnt - g0), 32'd1);
    bus_ssyn_in_h = 1'b0;
    step();
  endtask

  initial begin
    int g0;
    RESET         = 1'b1;
    init_in_h     = 1'b0;
    intreqs       = 4'b0000;
    irvecs        = {8'o164, 8'o160, 8'o170, 8'o100};
    bus_bg_in_h   = 1'b0;
    bus_bbsy_in_h = 1'b0;
    bus_ssyn_in_h = 1'b0;
    step();
    step();
    RESET = 1'b0;
    check("reset outs", {15'd0, intgnt, igvec, bus_br_out_h, bus_bg_out_h, bus_sack_out_h,
                         bus_bbsy_out_h, bus_intr_out_h, |bus_d_out_h, 2'b00}, 32'd0);

    // 1: single request on dev2, dropped after the grant edge
    intreqs = 4'b0100;
    step();
    check("t1 br", 32'(bus_br_out_h), 32'd1);
    grant_cycle("t1", 8'o160, 1'b1);
    step();
    check("t1 br after", 32'(bus_br_out_h), 32'd0);

    // 2: dev1 and dev2 together, dev1 first, dev2 on the next BR/BG
    intreqs = 4'b0110;
    step();
    check("t2 br", 32'(bus_br_out_h), 32'd1);
    grant_cycle("t2a", 8'o170, 1'b0);
    intreqs = 4'b0100;
    step();
    check("t2 br again", 32'(bus_br_out_h), 32'd1);
    grant_cycle("t2b", 8'o160, 1'b0);
    intreqs = 4'b0000;
    step();
    check("t2 br after", 32'(bus_br_out_h), 32'd0);

    // 3: no request, grant passes through
    bus_bg_in_h = 1'b1;
    step();
    check("t3 bg_out", 32'(bus_bg_out_h), 32'd1);
    step();
    check("t3 bg_out hold", 32'(bus_bg_out_h), 32'd1);
    check("t3 no sack/bbsy", {30'd0, bus_sack_out_h, bus_bbsy_out_h}, 32'd0);
    bus_bg_in_h = 1'b0;
    step();
    check("t3 bg_out off", 32'(bus_bg_out_h), 32'd0);

    // 4: bus busy after grant holds GRANT
    intreqs = 4'b0001;
    step();
    bus_bg_in_h   = 1'b1;
    bus_bbsy_in_h = 1'b1;
    step();
    check("t4 sack", 32'(bus_sack_out_h), 32'd1);
    bus_bg_in_h = 1'b0;
    step();
    step();
    check("t4 wait bbsy", 32'(bus_bbsy_out_h), 32'd0);
    check("t4 wait sack", 32'(bus_sack_out_h), 32'd1);
    bus_bbsy_in_h = 1'b0;
    step();
    check("t4 bbsy", 32'(bus_bbsy_out_h), 32'd1);
    check("t4 d", 32'(bus_d_out_h), 32'o100);
    step();
    bus_ssyn_in_h = 1'b1;
    intreqs = 4'b0000;
    step();
    check("t4 igvec", 32'(igvec), 32'o100);
    bus_ssyn_in_h = 1'b0;
    step();
    step();

    // 5: INIT during VECT aborts without intgnt
    intreqs = 4'b0010;
    step();
    bus_bg_in_h = 1'b1;
    step();
    bus_bg_in_h = 1'b0;
    step();
    step();
    check("t5 in vect", 32'(bus_intr_out_h), 32'd1);
    g0 = n_gnt;
    init_in_h     = 1'b1;
    bus_ssyn_in_h = 1'b1;
    step();
    check("t5 init outs", {15'd0, intgnt, igvec, bus_br_out_h, bus_bg_out_h, bus_sack_out_h,
                           bus_bbsy_out_h, bus_intr_out_h, |bus_d_out_h, 2'b00}, 32'd0);
    init_in_h     = 1'b0;
    bus_ssyn_in_h = 1'b0;
    step();
    check("t5 no pulse", 32'(n_gnt - g0), 32'd0);
    check("t5 br idle", 32'(bus_br_out_h), 32'd1);
    intreqs = 4'b0000;
    step();
    check("t5 br off", 32'(bus_br_out_h), 32'd0);

`ifdef INTARB_TIMEOUT_EN
    // 6: no SSYN, VECT times out after 16 cycles
    intreqs = 4'b0001;
    step();
    bus_bg_in_h = 1'b1;
    step();
    bus_bg_in_h = 1'b0;
    step();
    step();
    g0 = n_gnt;
    for (int i = 0; i < 15; i++) step();
    check("t6 intr before", 32'(bus_intr_out_h), 32'd1);
    step();
    check("t6 timeout outs", {29'd0, bus_intr_out_h, bus_bbsy_out_h, |bus_d_out_h}, 32'd0);
    step();
    check("t6 br again", 32'(bus_br_out_h), 32'd1);
    check("t6 no pulse", 32'(n_gnt - g0), 32'd0);
    intreqs = 4'b0000;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
